// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the default data-segment base address.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR      = 3'd4,
    RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/dmem_lane.sv
// Little-endian lane logic: extracts/extends a load value from a RAM word and
// builds the merged word for sub-word stores.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{sign & sel_byte[7]}}, sel_byte};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{sign & sel_half[15]}}, sel_half};
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: CPU load/store port to a word-wide synchronous RAM,
// with address range/alignment checking and read-modify-write sub-word stores.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          AW          = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);

  // Request channel: a transfer happens on a rising edge with req_valid=1 and
  // req_ready=1; req_ready is high only in IDLE and all req_* are captured then.
  state_e state, next_state;

  logic          we_q, sign_q, err_q;
  logic [1:0]    size_q, lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q, old_q, rdata_q;

  logic [31:0] offset;
  logic        req_err, accept;
  logic [31:0] lane_word, load_val, merged;

  assign offset = req_addr - BASE_ADDR;
  assign accept = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (offset >= RANGE_BYTES) req_err = 1'b1;
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (req_addr[0]) req_err = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                           next_state = RESP;
          else if (req_we && req_size == SZ_WORD) next_state = WR;
          else                                   next_state = RD;
        end
      end
      RD:      next_state = RD_WAIT;
      RD_WAIT: next_state = we_q ? MERGE : RESP;
      MERGE:   next_state = RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        err_q   <= req_err;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        idx_q   <= offset[AW+1:2];
        wdata_q <= req_wdata;
      end
      if (state == RD_WAIT) begin
        if (we_q) old_q   <= mem_rdata;
        else      rdata_q <= load_val;
      end
    end
  end

  // Loads extract straight from the RAM output; merges use the captured old word.
  assign lane_word = (state == MERGE) ? old_q : mem_rdata;

  dmem_lane u_lane (
    .size     (size_q),
    .sign     (sign_q),
    .lane     (lane_q),
    .word     (lane_word),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign mem_en     = (state == RD) || (state == WR) || (state == MERGE);
  assign mem_we     = (state == WR) || (state == MERGE);
  assign mem_addr   = idx_q;
  assign mem_wdata  = (state == MERGE) ? merged : wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed loads/stores against a behavioural RAM, with a
// response scoreboard checking data, error flag and latency.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] ram [0:2047] = '{default: 32'h0};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int bad_en  = 0;
  bit err_phase = 1'b0;
  logic [31:0] last_rd = 32'h0;

  // Entry: {err, latency[2:0], rdata}
  logic [35:0] exp_q[$];
  int          acc_q[$];

  dmem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Clock / cycle counter / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  always @(negedge clk) if (err_phase && mem_en) bad_en <= bad_en + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none");
      end else begin
        logic [35:0] e;
        int          a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_err", {31'b0, resp_err}, {31'b0, e[35]});
        check("latency", 32'(cyc - a + 1), {29'b0, e[34:32]});
      end
    end
  end

  // Driver: presents a request and returns one cycle after acceptance with
  // req_valid still asserted; returns the accept edge index in acc.
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit track, output int acc);
    logic [31:0] rd;
    req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles expected 1");
      req_valid = 1'b0;
    end else begin
      if (track) begin
        rd = (we || exp_err) ? last_rd : exp_rd;
        if (!we && !exp_err) last_rd = exp_rd;
        exp_q.push_back({exp_err, lat[2:0], rd});
        acc_q.push_back(acc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic sign,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int acc;
    issue(we, size, sign, addr, wdata, exp_rd, exp_err, lat, 1'b1, acc);
    drain();
  endtask

  initial begin
    int a1, a2, ad;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {21'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Word store / load
    op(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    check("ram_w1_sw", ram[1], 32'hDEAD_BEEF);
    op(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

    // Sub-word loads
    op(1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'h0, 32'hFFFF_FFDE, 1'b0, 3);
    op(1'b0, 2'b00, 1'b0, 32'h1001_0007, 32'h0, 32'h0000_00DE, 1'b0, 3);
    op(1'b0, 2'b01, 1'b1, 32'h1001_0004, 32'h0, 32'hFFFF_BEEF, 1'b0, 3);
    op(1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0, 32'h0000_DEAD, 1'b0, 3);

    // Sub-word stores (read-modify-write)
    op(1'b1, 2'b00, 1'b0, 32'h1001_0005, 32'h0000_0012, 32'h0, 1'b0, 4);
    check("ram_w1_sb", ram[1], 32'hDEAD_12EF);
    op(1'b1, 2'b01, 1'b0, 32'h1001_0006, 32'h0000_3456, 32'h0, 1'b0, 4);
    check("ram_w1_sh", ram[1], 32'h3456_12EF);
    check("ram_w0_untouched", ram[0], 32'h0);
    check("ram_w2_untouched", ram[2], 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'h3456_12EF, 1'b0, 3);

    // Rejected accesses: no RAM activity at all
    err_phase = 1'b1;
    op(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, 1);
    op(1'b0, 2'b01, 1'b1, 32'h1001_0001, 32'h0, 32'h0, 1'b1, 1);
    op(1'b1, 2'b10, 1'b0, 32'h1000_FFFC, 32'h1111_1111, 32'h0, 1'b1, 1);
    op(1'b1, 2'b10, 1'b0, 32'h1001_2000, 32'h2222_2222, 32'h0, 1'b1, 1);
    op(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 1);
    err_phase = 1'b0;
    check("err_mem_en_cycles", 32'(bad_en), 32'd0);
    check("err_ram_w1", ram[1], 32'h3456_12EF);
    check("err_ram_w2047", ram[2047], 32'h0);

    // Last legal word, then back-to-back loads with req_valid held high
    op(1'b1, 2'b10, 1'b0, 32'h1001_1FFC, 32'hA5A5_5A5A, 32'h0, 1'b0, 2);
    check("ram_last_word", ram[2047], 32'hA5A5_5A5A);
    issue(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'h3456_12EF, 1'b0, 3, 1'b1, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h1001_1FFC, 32'h0, 32'hA5A5_5A5A, 1'b0, 3, 1'b1, a2);
    drain();
    check("b2b_accept_gap", 32'(a2 - a1), 32'd4);

    // Reset during MERGE of an sb aborts without a response
    op(1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
    issue(1'b1, 2'b00, 1'b0, 32'h1001_0020, 32'h0000_0055, 32'h0, 1'b0, 4, 1'b0, ad);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_in_merge_we", {31'b0, mem_we}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_rd = 32'h0;
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_mem_en", {31'b0, mem_en}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    op(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller between the CPU load/store port and the word-wide synchronous data RAM.
- Converts CPU byte addresses in the MIPS data segment (base 0x10010000) to RAM word indices.
- Supports lb/lbu/lh/lhu/lw and sb/sh/sw; sub-word stores use read-modify-write.
- Uses a valid/ready request channel and a one-cycle response pulse, and flags out-of-range or misaligned accesses.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of RAM word 0.
- DEPTH_WORDS, 2048, RAM depth in 32-bit words.
- AW, 11, RAM word-address width, equal to clog2(DEPTH_WORDS).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_sign  in  1  sign-extend sub-word loads (lb/lh); 0 = zero-extend.
- req_addr  in  32  CPU byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_rdata  out  32  load result; valid with resp_valid, held until the next response.
- resp_err  out  1  valid with resp_valid: access rejected, no RAM write performed.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM word index.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid one cycle after mem_en=1 with mem_we=0.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0; all capture registers cleared.
- Reset mid-operation aborts the request and gives no response. A RAM write presented in the cycle where reset is sampled may commit.
- Handshake: a request is accepted on an edge where req_valid=1 and req_ready=1. All req_* fields are captured at that edge.
- req_ready=1 only in IDLE. The CPU holds its request while req_ready=0.
- Offset = req_addr - BASE_ADDR (32-bit, wrapping). Word index = offset[AW+1:2].
- Error conditions:
  - offset >= 4*DEPTH_WORDS, which covers addresses below BASE via wrap;
  - size 01 with addr[0]=1;
  - size 10 with addr[1:0]!=0;
  - size 11.
- Byte lanes are little-endian. Byte lane = addr[1:0]; halfword lane = addr[1] (bits 15:0 or 31:16).
- FSM states: IDLE, RD, RD_WAIT, MERGE, WR, RESP. From IDLE on accept (T = accept edge):
  - Error: go to RESP. No mem_en during the request. resp_err=1, resp_rdata unchanged. resp_valid in cycle T+1.
  - sw: WR drives mem_en=1, mem_we=1, mem_wdata=req_wdata, then RESP. Write at edge T+2; resp_valid in cycle T+2.
  - Load: RD drives mem_en=1, mem_we=0. RD_WAIT captures mem_rdata, then extract/extend into resp_rdata. Then RESP; resp_valid in cycle T+3.
  - sb/sh: RD, then RD_WAIT captures the old word. MERGE drives mem_en=1, mem_we=1 with only the target lane replaced, then RESP; resp_valid in cycle T+4.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_err=0 for successful accesses.
- A new request may be accepted in the first IDLE cycle after RESP. Back-to-back throughput is one request per (latency+1) cycles.
- mem_en=0 in IDLE and RESP; mem_we=1 only in WR and MERGE.
- req_valid deasserting while the controller is not in IDLE is ignored.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum (IDLE, RD, RD_WAIT, MERGE, WR, RESP);
  - default BASE_ADDR constant.
- Sub-module dmem_lane (combinational): given size, sign, and lane offset, produces the extracted/extended load value and the merged store word.
- dmem_ctrl holds the FSM, capture registers, and range/alignment check.

Test Plan:
- sw 0xDEADBEEF @0x10010004, then lw @0x10010004 -> memory word 1 = 0xDEADBEEF. Store resp at T+2, load resp at T+3 with rdata 0xDEADBEEF, err=0.
- Word 1 = 0xDEADBEEF; lb @0x10010007 -> 0xFFFFFFDE; lbu @0x10010007 -> 0x000000DE; lh @0x10010004 -> 0xFFFFBEEF; lhu @0x10010006 -> 0x0000DEAD.
- sb 0x12 @0x10010005, then sh 0x3456 @0x10010006 -> word 1 = 0x34561 2EF (0x345612EF). Each store resp at T+4; only the target lanes change.
- Errors: lw @0x10010002, lh @0x10010001, sw @0x1000FFFC, sw @0x10012000 -> resp_err=1 at T+1. No cycle with mem_we=1; memory unchanged.
- Hold req_valid=1 continuously with two loads -> second accepted only after the first RESP cycle; req_ready=0 during RD/RD_WAIT/RESP.
- Assert rst=0 during the MERGE of an sb -> next cycle IDLE, req_ready=1, resp_valid=0, mem_en=0; a subsequent lw returns correctly.
